// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer.
//   - default widths for PC, loop count and run-cycle counter
//   - sequencer state encoding
//   - reserved "idle" instruction address (fetch disabled while PC == 0)
package pc_seq_pkg;

    localparam int unsigned DEF_IM_ADDR_WIDTH     = 16;
    localparam int unsigned DEF_LOOP_COUNT_WIDTH  = 16;
    localparam int unsigned DEF_CYCLE_COUNT_WIDTH = 32;

    localparam int unsigned IDLE_ADDR = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

endpackage

// File: rtl/pc_seq_loop_controller.sv
// Single-level zero-overhead hardware loop bookkeeping.
// Ports:
//   iClk, iReset       clock, synchronous active-low reset
//   cfg_i              load loop start/end/count (wins over clear/step)
//   loop_start_i/_end_i/count_i  new loop registers
//   pc_i               current PC
//   step_i             sequencer took the sequential/loop path this cycle
//   clear_i            halt: deactivate loop
//   loop_back_c_o      PC is at loop end and more iterations remain
//   loop_target_c_o    loop body start address
module loop_controller
    import pc_seq_pkg::*;
#(
    parameter int unsigned AW = DEF_IM_ADDR_WIDTH,
    parameter int unsigned CW = DEF_LOOP_COUNT_WIDTH
) (
    input  logic          iClk,
    input  logic          iReset,
    input  logic          cfg_i,
    input  logic [AW-1:0] loop_start_i,
    input  logic [AW-1:0] loop_end_i,
    input  logic [CW-1:0] loop_count_i,
    input  logic [AW-1:0] pc_i,
    input  logic          step_i,
    input  logic          clear_i,
    output logic          loop_back_c_o,
    output logic [AW-1:0] loop_target_c_o
);

    logic [AW-1:0] start_q, start_d;
    logic [AW-1:0] end_q, end_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          at_end;

    assign at_end          = (pc_i == end_q);
    assign loop_back_c_o   = at_end && (rem_q > CW'(1));
    assign loop_target_c_o = start_q;

    // Remaining count drops on every pass through the loop end, so the
    // final pass (rem == 1) falls through to PC+1 and leaves the loop inactive.
    always_comb begin
        start_d = start_q;
        end_d   = end_q;
        rem_d   = rem_q;
        if (cfg_i) begin
            start_d = loop_start_i;
            end_d   = loop_end_i;
            rem_d   = loop_count_i;
        end else if (clear_i) begin
            start_d = '0;
            end_d   = '0;
            rem_d   = '0;
        end else if (step_i && at_end && (rem_q != '0)) begin
            rem_d   = rem_q - CW'(1);
        end
    end

    always_ff @(posedge iClk) begin
        if (!iReset) begin
            start_q <= '0;
            end_q   <= '0;
            rem_q   <= '0;
        end else begin
            start_q <= start_d;
            end_q   <= end_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for a CGRA function-unit fetch stage.
// Ports:
//   iClk, iReset                 clock, synchronous active-low reset
//   iStart, iStartAddress        begin execution (address 0 ignored)
//   iStall, iBranch, iBranchTarget, iHalt   run-time flow control
//   iLoopConfig, iLoopStart, iLoopEnd, iLoopCount   hardware loop setup
//   oProgramCounter              registered fetch address (0 = idle)
//   oRunning, oDone              state == RUN / state == HALT
//   oOverflow                    sticky PC-wrap flag
//   oCycleCount                  saturating count of RUN cycles
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned IM_ADDR_WIDTH     = DEF_IM_ADDR_WIDTH,
    parameter int unsigned LOOP_COUNT_WIDTH  = DEF_LOOP_COUNT_WIDTH,
    parameter int unsigned CYCLE_COUNT_WIDTH = DEF_CYCLE_COUNT_WIDTH
) (
    input  logic                         iClk,
    input  logic                         iReset,
    input  logic                         iStart,
    input  logic [IM_ADDR_WIDTH-1:0]     iStartAddress,
    input  logic                         iStall,
    input  logic                         iBranch,
    input  logic [IM_ADDR_WIDTH-1:0]     iBranchTarget,
    input  logic                         iHalt,
    input  logic                         iLoopConfig,
    input  logic [IM_ADDR_WIDTH-1:0]     iLoopStart,
    input  logic [IM_ADDR_WIDTH-1:0]     iLoopEnd,
    input  logic [LOOP_COUNT_WIDTH-1:0]  iLoopCount,
    output logic [IM_ADDR_WIDTH-1:0]     oProgramCounter,
    output logic                         oRunning,
    output logic                         oDone,
    output logic                         oOverflow,
    output logic [CYCLE_COUNT_WIDTH-1:0] oCycleCount
);

    localparam logic [IM_ADDR_WIDTH-1:0] IDLE_PC = IM_ADDR_WIDTH'(IDLE_ADDR);

    state_e                         state_q, state_d;
    logic [IM_ADDR_WIDTH-1:0]       pc_q, pc_d;
    logic [CYCLE_COUNT_WIDTH-1:0]   cyc_q, cyc_d;
    logic                           ovf_q, ovf_d;
    logic                           running_q, done_q;
    logic                           loop_step, loop_clear;
    logic                           loop_back;
    logic [IM_ADDR_WIDTH-1:0]       loop_target;

    loop_controller #(
        .AW (IM_ADDR_WIDTH),
        .CW (LOOP_COUNT_WIDTH)
    ) u_loop (
        .iClk            (iClk),
        .iReset          (iReset),
        .cfg_i           (iLoopConfig),
        .loop_start_i    (iLoopStart),
        .loop_end_i      (iLoopEnd),
        .loop_count_i    (iLoopCount),
        .pc_i            (pc_q),
        .step_i          (loop_step),
        .clear_i         (loop_clear),
        .loop_back_c_o   (loop_back),
        .loop_target_c_o (loop_target)
    );

    // Next-state and next-PC selection: halt > stall > branch > loop-back > PC+1.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cyc_d      = cyc_q;
        ovf_d      = ovf_q;
        loop_step  = 1'b0;
        loop_clear = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (iStart && (iStartAddress != IDLE_PC)) begin
                    state_d = ST_RUN;
                    pc_d    = iStartAddress;
                    cyc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_RUN: begin
                cyc_d = (&cyc_q) ? cyc_q : cyc_q + CYCLE_COUNT_WIDTH'(1);
                if (iHalt || (!iStall && iBranch && (iBranchTarget == IDLE_PC))) begin
                    state_d    = ST_HALT;
                    pc_d       = IDLE_PC;
                    loop_clear = 1'b1;
                end else if (iStall) begin
                    pc_d = pc_q;
                end else if (iBranch) begin
                    pc_d = iBranchTarget;
                end else begin
                    loop_step = 1'b1;
                    if (loop_back) begin
                        pc_d = loop_target;
                    end else if (&pc_q) begin
                        // Wrapping onto the reserved idle address ends the program.
                        state_d = ST_HALT;
                        pc_d    = IDLE_PC;
                        ovf_d   = 1'b1;
                    end else begin
                        pc_d = pc_q + IM_ADDR_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = IDLE_PC;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iReset) begin
            state_q   <= ST_IDLE;
            pc_q      <= IDLE_PC;
            cyc_q     <= '0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cyc_q     <= cyc_d;
            ovf_q     <= ovf_d;
            running_q <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_HALT);
        end
    end

    assign oProgramCounter = pc_q;
    assign oRunning        = running_q;
    assign oDone           = done_q;
    assign oOverflow       = ovf_q;
    assign oCycleCount     = cyc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Vector-table bench for pc_sequencer with an expected-output queue.
module tb_pc_sequencer;

    localparam int unsigned AW = 16;
    localparam int unsigned LW = 16;
    localparam int unsigned CW = 32;

    logic          iClk = 1'b0;
    logic          iReset;
    logic          iStart;
    logic [AW-1:0] iStartAddress;
    logic          iStall;
    logic          iBranch;
    logic [AW-1:0] iBranchTarget;
    logic          iHalt;
    logic          iLoopConfig;
    logic [AW-1:0] iLoopStart;
    logic [AW-1:0] iLoopEnd;
    logic [LW-1:0] iLoopCount;
    logic [AW-1:0] oProgramCounter;
    logic          oRunning;
    logic          oDone;
    logic          oOverflow;
    logic [CW-1:0] oCycleCount;

    always #5 iClk = ~iClk;

    pc_sequencer #(
        .IM_ADDR_WIDTH     (AW),
        .LOOP_COUNT_WIDTH  (LW),
        .CYCLE_COUNT_WIDTH (CW)
    ) dut (
        .iClk            (iClk),
        .iReset          (iReset),
        .iStart          (iStart),
        .iStartAddress   (iStartAddress),
        .iStall          (iStall),
        .iBranch         (iBranch),
        .iBranchTarget   (iBranchTarget),
        .iHalt           (iHalt),
        .iLoopConfig     (iLoopConfig),
        .iLoopStart      (iLoopStart),
        .iLoopEnd        (iLoopEnd),
        .iLoopCount      (iLoopCount),
        .oProgramCounter (oProgramCounter),
        .oRunning        (oRunning),
        .oDone           (oDone),
        .oOverflow       (oOverflow),
        .oCycleCount     (oCycleCount)
    );

    typedef struct {
        logic          rst_n;
        logic          start;
        logic [AW-1:0] saddr;
        logic          stall;
        logic          branch;
        logic [AW-1:0] btgt;
        logic          halt;
        logic          cfg;
        logic [AW-1:0] ls;
        logic [AW-1:0] le;
        logic [LW-1:0] lc;
    } in_t;

    typedef struct {
        logic [AW-1:0] pc;
        logic          run;
        logic          done;
        logic          ovf;
        logic [CW-1:0] cyc;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t vecs[$];
    out_t sb[$];
    in_t  cur;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic in_t nop_in();
        in_t x;
        x.rst_n = 1'b1;  x.start = 1'b0;  x.saddr = '0;
        x.stall = 1'b0;  x.branch = 1'b0; x.btgt = '0;
        x.halt  = 1'b0;  x.cfg = 1'b0;
        x.ls = '0; x.le = '0; x.lc = '0;
        return x;
    endfunction

    // Record the inputs accumulated in cur with the outputs expected after the edge.
    task automatic ex(input logic [AW-1:0] pc, input logic run, input logic done,
                      input logic ovf, input int cyc);
        vec_t v;
        v.i      = cur;
        v.o.pc   = pc;
        v.o.run  = run;
        v.o.done = done;
        v.o.ovf  = ovf;
        v.o.cyc  = CW'(cyc);
        vecs.push_back(v);
        cur = nop_in();
    endtask

    task automatic st(input logic [AW-1:0] a);
        cur.start = 1'b1;
        cur.saddr = a;
    endtask

    task automatic br(input logic [AW-1:0] t);
        cur.branch = 1'b1;
        cur.btgt   = t;
    endtask

    task automatic cfg(input logic [AW-1:0] s, input logic [AW-1:0] e, input logic [LW-1:0] c);
        cur.cfg = 1'b1;
        cur.ls  = s;
        cur.le  = e;
        cur.lc  = c;
    endtask

    task automatic apply(input in_t x);
        iReset        = x.rst_n;
        iStart        = x.start;
        iStartAddress = x.saddr;
        iStall        = x.stall;
        iBranch       = x.branch;
        iBranchTarget = x.btgt;
        iHalt         = x.halt;
        iLoopConfig   = x.cfg;
        iLoopStart    = x.ls;
        iLoopEnd      = x.le;
        iLoopCount    = x.lc;
    endtask

    task automatic chk(input int idx, input string nm, input logic [CW-1:0] act,
                       input logic [CW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", idx, nm, act, exp);
        end
    endtask

    initial begin
        int   loop_seq[10];
        out_t e;

        cur = nop_in();
        cur.rst_n = 1'b0;
        apply(cur);

        // Reset, idle behaviour, start/stall/branch/halt priorities
        cur.rst_n = 1'b0; ex(16'h0000, 0, 0, 0, 0);
        cur.rst_n = 1'b0; ex(16'h0000, 0, 0, 0, 0);
        ex(16'h0000, 0, 0, 0, 0);
        st(16'h0000); ex(16'h0000, 0, 0, 0, 0);
        st(16'h0010); ex(16'h0010, 1, 0, 0, 0);
        ex(16'h0011, 1, 0, 0, 1);
        ex(16'h0012, 1, 0, 0, 2);
        cur.stall = 1'b1; ex(16'h0012, 1, 0, 0, 3);
        cur.stall = 1'b1; br(16'h0040); ex(16'h0012, 1, 0, 0, 4);
        cur.stall = 1'b1; ex(16'h0012, 1, 0, 0, 5);
        ex(16'h0013, 1, 0, 0, 6);
        st(16'h0070); ex(16'h0014, 1, 0, 0, 7);
        ex(16'h0015, 1, 0, 0, 8);
        cur.halt = 1'b1; ex(16'h0000, 0, 1, 0, 9);
        ex(16'h0000, 0, 1, 0, 9);
        st(16'h0000); ex(16'h0000, 0, 1, 0, 9);
        st(16'h0030); ex(16'h0030, 1, 0, 0, 0);
        ex(16'h0031, 1, 0, 0, 1);
        cur.halt = 1'b1; br(16'h0040); ex(16'h0000, 0, 1, 0, 2);
        st(16'h0032); ex(16'h0032, 1, 0, 0, 0);
        br(16'h0000); ex(16'h0000, 0, 1, 0, 1);
        st(16'h0033); ex(16'h0033, 1, 0, 0, 0);
        cur.stall = 1'b1; br(16'h0000); ex(16'h0033, 1, 0, 0, 1);
        cur.stall = 1'b1; cur.halt = 1'b1; ex(16'h0000, 0, 1, 0, 2);

        // Hardware loop: 3 iterations of 0x20..0x22
        cur.rst_n = 1'b0; ex(16'h0000, 0, 0, 0, 0);
        cfg(16'h0020, 16'h0022, 16'd3); ex(16'h0000, 0, 0, 0, 0);
        st(16'h0020); ex(16'h0020, 1, 0, 0, 0);
        loop_seq = '{'h21, 'h22, 'h20, 'h21, 'h22, 'h20, 'h21, 'h22, 'h23, 'h24};
        for (int i = 0; i < 10; i++) ex(AW'(loop_seq[i]), 1, 0, 0, i + 1);

        // Config at PC == new loop end: this cycle still uses the old (inactive) loop
        cfg(16'h0023, 16'h0024, 16'd2); ex(16'h0025, 1, 0, 0, 11);
        br(16'h0023); ex(16'h0023, 1, 0, 0, 12);
        ex(16'h0024, 1, 0, 0, 13);
        ex(16'h0023, 1, 0, 0, 14);
        ex(16'h0024, 1, 0, 0, 15);
        ex(16'h0025, 1, 0, 0, 16);

        // Branch away from loop end must not consume an iteration
        cfg(16'h0060, 16'h0061, 16'd2); ex(16'h0026, 1, 0, 0, 17);
        br(16'h0060); ex(16'h0060, 1, 0, 0, 18);
        ex(16'h0061, 1, 0, 0, 19);
        br(16'h0050); ex(16'h0050, 1, 0, 0, 20);
        br(16'h0061); ex(16'h0061, 1, 0, 0, 21);
        ex(16'h0060, 1, 0, 0, 22);
        ex(16'h0061, 1, 0, 0, 23);
        ex(16'h0062, 1, 0, 0, 24);

        // Reset mid-loop and mid-stall overrides everything and clears the loop
        cfg(16'h0070, 16'h0071, 16'd5); ex(16'h0063, 1, 0, 0, 25);
        br(16'h0070); ex(16'h0070, 1, 0, 0, 26);
        ex(16'h0071, 1, 0, 0, 27);
        cur.stall = 1'b1; ex(16'h0071, 1, 0, 0, 28);
        cur.rst_n = 1'b0; cur.stall = 1'b1; st(16'h0005); br(16'h0009);
        ex(16'h0000, 0, 0, 0, 0);
        st(16'h0071); ex(16'h0071, 1, 0, 0, 0);
        ex(16'h0072, 1, 0, 0, 1);
        cur.halt = 1'b1; ex(16'h0000, 0, 1, 0, 2);

        // PC wrap: overflow and halt, then restart clears overflow
        st(16'hFFFE); ex(16'hFFFE, 1, 0, 0, 0);
        ex(16'hFFFF, 1, 0, 0, 1);
        ex(16'h0000, 0, 1, 1, 2);
        ex(16'h0000, 0, 1, 1, 2);
        st(16'h0010); ex(16'h0010, 1, 0, 0, 0);

        // Halt clears loop registers
        cfg(16'h0040, 16'h0041, 16'd3); ex(16'h0011, 1, 0, 0, 1);
        cur.halt = 1'b1; ex(16'h0000, 0, 1, 0, 2);
        st(16'h0040); ex(16'h0040, 1, 0, 0, 0);
        ex(16'h0041, 1, 0, 0, 1);
        ex(16'h0042, 1, 0, 0, 2);

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge iClk);
            apply(vecs[k].i);
            sb.push_back(vecs[k].o);
            @(posedge iClk);
            #1;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL vec%0d scoreboard: got empty queue expected entry", k);
            end else begin
                e = sb.pop_front();
                chk(k, "pc",      CW'(oProgramCounter), CW'(e.pc));
                chk(k, "running", CW'(oRunning),        CW'(e.run));
                chk(k, "done",    CW'(oDone),           CW'(e.done));
                chk(k, "overflow", CW'(oOverflow),      CW'(e.ovf));
                chk(k, "cycles",  oCycleCount,          e.cyc);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
